// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Clocked writer for a gated SR latch storage cell. Each write request
// (ReqValid/ReqReady handshake, ReqBit = value to store) becomes a fixed,
// glitch-free sequence on the latch nets:
//
//   SETUP  : S/R presented, En low   (SETUP_CYC cycles)
//   PULSE  : S/R held,      En high  (PULSE_CYC cycles)
//   HOLD   : S/R held,      En low   (1 cycle)
//   SETTLE : S/R/En all low          (SETTLE_CYC cycles)
//
// The latch outputs are then read back through two-flop synchronizers and
// compared with the requested value. Done pulses for one cycle at the end of
// every write; Err pulses with Done when the readback disagrees or the latch
// outputs are not complementary.
//
// Every output comes straight from a flop, so the asynchronous latch never
// sees combinational hazards from the control logic.
//
// Parameters
//   SETUP_CYC  : cycles of stable S/R with En low before En rises (1..2^CW-1)
//   PULSE_CYC  : cycles En is held high                             (1..2^CW-1)
//   SETTLE_CYC : cycles after S/R release before readback           (2..2^CW-1)
//   CW         : phase counter width
//
// Ports
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset; aborts any write in flight
//   ReqValid  in   write request present
//   ReqBit    in   value to store (1 = set via S, 0 = reset via R)
//   ReqReady  out  driver idle; accept on ReqValid & ReqReady at the edge
//   S         out  latch set input
//   R         out  latch reset input
//   En        out  latch enable
//   Q         in   latch output (asynchronous)
//   notQ      in   latch complementary output (asynchronous)
//   Done      out  one-cycle pulse when a write completes
//   Err       out  one-cycle pulse with Done when readback fails
//   StoredQ   out  synchronized Q captured at the last readback
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2,
    parameter int CW         = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic ReqValid,
    input  logic ReqBit,
    output logic ReqReady,
    output logic S,
    output logic R,
    output logic En,
    input  logic Q,
    input  logic notQ,
    output logic Done,
    output logic Err,
    output logic StoredQ
);

    // Counter reload values: each phase counts down to zero, so a phase of
    // N cycles loads N-1.
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE
    } stateT;

    // -------------------------------------------------------------------------
    // Readback synchronizers
    // -------------------------------------------------------------------------
    logic qMeta;
    logic qSync;
    logic nqMeta;
    logic nqSync;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            qMeta  <= 1'b0;
            qSync  <= 1'b0;
            nqMeta <= 1'b0;
            nqSync <= 1'b0;
        end else begin
            qMeta  <= Q;
            qSync  <= qMeta;
            nqMeta <= notQ;
            nqSync <= nqMeta;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    stateT         state;
    stateT         stateNxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNxt;
    logic          bitLat;     // request value captured at accept
    logic          bitNxt;

    logic sNxt;
    logic rNxt;
    logic enNxt;
    logic readyNxt;
    logic doneNxt;
    logic errNxt;
    logic storedNxt;

    logic accept;
    logic cntZero;

    // ReqReady is itself a flop that mirrors "state is IDLE", except that it
    // stays low on the first edge after reset; gating accept with it makes
    // that first post-reset edge ignore ReqValid.
    assign accept  = ReqValid && ReqReady;
    assign cntZero = (cnt == '0);

    // NOTE: every variable written below gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        bitNxt    = bitLat;
        doneNxt   = 1'b0;
        errNxt    = 1'b0;
        storedNxt = StoredQ;

        case (state)
            IDLE: begin
                if (accept) begin
                    stateNxt = SETUP;
                    cntNxt   = SETUP_LOAD;
                    bitNxt   = ReqBit;
                end
            end

            SETUP: begin
                if (cntZero) begin
                    stateNxt = PULSE;
                    cntNxt   = PULSE_LOAD;
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end

            PULSE: begin
                if (cntZero) begin
                    stateNxt = HOLD;
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end

            // One cycle with En already low and S/R still driven, so the
            // latch closes before its data inputs move.
            HOLD: begin
                stateNxt = SETTLE;
                cntNxt   = SETTLE_LOAD;
            end

            SETTLE: begin
                if (cntZero) begin
                    stateNxt  = IDLE;
                    doneNxt   = 1'b1;
                    storedNxt = qSync;
                    // A healthy latch shows the written value on Q and its
                    // complement on notQ; equal outputs mean S/R both active
                    // or a latch that has not resolved yet.
                    errNxt    = (qSync != bitLat) || (qSync == nqSync);
                end else begin
                    cntNxt = cnt - CW'(1);
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state they belong to.
        sNxt     = 1'b0;
        rNxt     = 1'b0;
        enNxt    = 1'b0;
        readyNxt = 1'b0;

        case (stateNxt)
            IDLE: begin
                readyNxt = 1'b1;
            end
            SETUP: begin
                sNxt = bitNxt;
                rNxt = !bitNxt;
            end
            PULSE: begin
                sNxt  = bitNxt;
                rNxt  = !bitNxt;
                enNxt = 1'b1;
            end
            HOLD: begin
                sNxt = bitNxt;
                rNxt = !bitNxt;
            end
            default: begin
                // SETTLE: latch nets released
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bitLat   <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            En       <= 1'b0;
            ReqReady <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            StoredQ  <= 1'b0;
        end else begin
            state    <= stateNxt;
            cnt      <= cntNxt;
            bitLat   <= bitNxt;
            S        <= sNxt;
            R        <= rNxt;
            En       <= enNxt;
            ReqReady <= readyNxt;
            Done     <= doneNxt;
            Err      <= errNxt;
            StoredQ  <= storedNxt;
        end
    end

    // -------------------------------------------------------------------------
    // Latch-interface invariants
    // -------------------------------------------------------------------------
    // S and R are never driven together.
    assert property (@(posedge Clk) disable iff (!Rst_n) !(S && R));

    // While En is high the latch is transparent, so S/R must not move.
    assert property (@(posedge Clk) disable iff (!Rst_n) En |-> $stable({S, R}));

endmodule
